et_stream_decoder: RTL and testbench

- Receiving end of the early-termination stochastic-computing datapath.
- Consumes a serial stochastic bitstream whose length is 2^L bits, as produced by the bypass-counter-driven generator.
- Accumulates the ones count and returns a full-precision value plus a threshold decision.
- Stops consuming bits as soon as the decision can no longer change. It sits between the SC compute array and the result/readback logic.

---
 rtl/et_stream_decoder.sv | 107 ++++++++++
 tb/tb_et_stream_decoder.sv | 190 +++++++++++++++++++
 2 files changed

// File: rtl/et_stream_decoder.sv
// Early-termination stochastic bitstream decoder: counts ones over a 2^L-bit stream
// and stops as soon as the threshold decision is settled (early termination enabled by ET_THRESH_EN).
module et_stream_decoder #(
   parameter int WIDTH = 8
) (
   input  logic                       clk,
   input  logic                       rst_n,
   input  logic                       start,
   input  logic [$clog2(WIDTH+1)-1:0] len_log2,
   input  logic [WIDTH:0]             thr,
   input  logic                       in_valid,
   input  logic                       in_bit,
   output logic                       in_ready,
   output logic                       out_valid,
   input  logic                       out_ready,
   output logic [WIDTH:0]             value,
   output logic                       decision,
   output logic                       early,
   output logic [WIDTH:0]             n_used
);
   localparam int LW = $clog2(WIDTH+1);
   localparam int VW = WIDTH + 2;

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t          state, stateNext;
   logic [LW-1:0]   lenQ, lenClamp, shamt;
   logic [WIDTH:0]  thrQ, onesQ, nQ, onesNext, nNext;
   logic [VW-1:0]   fullLen, onesScaled, remScaled, thrExt;
   logic            accept, isFull, detTrue, detFalse, stop, earlyNext;

   // Termination terms are evaluated on the post-accept counts, one bit wider than
   // the counters so the scaled remainder never overflows.
   assign lenClamp   = (len_log2 > LW'(WIDTH)) ? LW'(WIDTH) : len_log2;
   assign shamt      = LW'(WIDTH) - lenQ;
   assign onesNext   = onesQ + {{WIDTH{1'b0}}, in_bit};
   assign nNext      = nQ + {{WIDTH{1'b0}}, 1'b1};
   assign fullLen    = VW'(1) << lenQ;
   assign thrExt     = VW'(thrQ);
   assign onesScaled = VW'(onesNext) << shamt;
   assign remScaled  = (VW'(onesNext) + fullLen - VW'(nNext)) << shamt;
   assign isFull     = (VW'(nNext) == fullLen);
   assign detTrue    = (onesScaled >= thrExt);
   assign detFalse   = (remScaled < thrExt);
   assign accept     = in_valid && (state == RUN);

`ifdef ET_THRESH_EN
   assign stop      = isFull || detTrue || detFalse;
   assign earlyNext = !isFull;
`else
   assign stop      = isFull;
   assign earlyNext = 1'b0;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= stateNext;
   end

   always_comb begin
      stateNext = state;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      case (state)
         IDLE: if (start) stateNext = RUN;
         RUN: begin
            in_ready = 1'b1;
            if (in_valid && stop) stateNext = DONE;
         end
         DONE: begin
            out_valid = 1'b1;
            if (out_ready) stateNext = IDLE;
         end
         default: stateNext = IDLE;
      endcase
   end

   // Result registers are only written by the terminating sample, so they hold
   // through DONE and keep their last values back in IDLE.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         lenQ     <= '0;
         thrQ     <= '0;
         onesQ    <= '0;
         nQ       <= '0;
         value    <= '0;
         decision <= 1'b0;
         early    <= 1'b0;
         n_used   <= '0;
      end else if (state == IDLE && start) begin
         lenQ  <= lenClamp;
         thrQ  <= thr;
         onesQ <= '0;
         nQ    <= '0;
      end else if (accept) begin
         onesQ <= onesNext;
         nQ    <= nNext;
         if (stop) begin
            value    <= onesScaled[WIDTH:0];
            decision <= detTrue;
            early    <= earlyNext;
            n_used   <= nNext;
         end
      end
   end

endmodule

// File: tb/tb_et_stream_decoder.sv
// Directed scoreboard bench for et_stream_decoder; expectations follow ET_THRESH_EN.
module tb_et_stream_decoder;
   localparam int WIDTH = 8;
`ifdef ET_THRESH_EN
   localparam bit ET = 1'b1;
`else
   localparam bit ET = 1'b0;
`endif

   typedef struct {
      string      tag;
      logic [8:0] value;
      logic       decision;
      logic       early;
      logic [8:0] nUsed;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       start;
   logic [3:0] len_log2;
   logic [8:0] thr;
   logic       in_valid;
   logic       in_bit;
   logic       in_ready;
   logic       out_valid;
   logic       out_ready;
   logic [8:0] value;
   logic       decision;
   logic       early;
   logic [8:0] n_used;

   int   checks = 0;
   int   errors = 0;
   exp_t sbQ[$];

   et_stream_decoder #(.WIDTH(WIDTH)) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .len_log2(len_log2), .thr(thr),
      .in_valid(in_valid), .in_bit(in_bit), .in_ready(in_ready),
      .out_valid(out_valid), .out_ready(out_ready), .value(value),
      .decision(decision), .early(early), .n_used(n_used)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic startStream(input logic [3:0] l, input logic [8:0] t);
      @(negedge clk);
      start    = 1'b1;
      len_log2 = l;
      thr      = t;
      @(negedge clk);
      start = 1'b0;
      check("in_ready_rise", 32'(in_ready), 1);
   endtask

   // Feeds bits LSB-first while the decoder is ready; returns how many were accepted.
   task automatic applyStimulus(input int len, input logic [255:0] bits, input bit gapped,
                                output int acc);
      int i   = 0;
      int cyc = 0;
      acc = 0;
      while (i < len && cyc < 600 && in_ready === 1'b1) begin
         in_valid = gapped ? (cyc % 2 == 0) : 1'b1;
         in_bit   = bits[i];
         @(posedge clk);
         if (in_valid) begin
            i++;
            acc++;
         end
         @(negedge clk);
         in_valid = 1'b0;
         cyc++;
      end
      in_valid = 1'b0;
   endtask

   task automatic checkOutput(input bit stall, input int acc);
      int   waitCyc = 0;
      exp_t e;
      while (out_valid !== 1'b1 && waitCyc < 4) begin
         @(negedge clk);
         waitCyc++;
      end
      check("out_valid_rise", 32'(out_valid), 1);
      check("in_ready_done", 32'(in_ready), 0);
      if (sbQ.size() == 0) begin
         errors++;
         $display("[TB] FAIL scoreboard_empty observed 0 entries expected 1");
         return;
      end
      e = sbQ.pop_front();
      check({e.tag, "_value"},    32'(value),    32'(e.value));
      check({e.tag, "_decision"}, 32'(decision), 32'(e.decision));
      check({e.tag, "_early"},    32'(early),    32'(e.early));
      check({e.tag, "_n_used"},   32'(n_used),   32'(e.nUsed));
      check({e.tag, "_accepted"}, 32'(acc),      32'(e.nUsed));
      if (stall) begin
         for (int k = 0; k < 5; k++) begin
            start = (k == 2);
            @(negedge clk);
            check("stall_out_valid", 32'(out_valid), 1);
            check("stall_in_ready",  32'(in_ready),  0);
            check("stall_value",     32'(value),     32'(e.value));
            check("stall_n_used",    32'(n_used),    32'(e.nUsed));
         end
         start = 1'b0;
      end
      out_ready = 1'b1;
      @(negedge clk);
      out_ready = 1'b0;
      check("idle_out_valid", 32'(out_valid), 0);
      check("idle_in_ready",  32'(in_ready),  0);
      check("idle_value_kept", 32'(value),    32'(e.value));
   endtask

   initial begin
      int acc;
      rst_n     = 1'b0;
      start     = 1'b0;
      len_log2  = '0;
      thr       = '0;
      in_valid  = 1'b0;
      in_bit    = 1'b0;
      out_ready = 1'b0;
      #12;
      check("rst_in_ready",  32'(in_ready),  0);
      check("rst_out_valid", 32'(out_valid), 0);
      check("rst_value",     32'(value),     0);
      check("rst_decision",  32'(decision),  0);
      check("rst_early",     32'(early),     0);
      check("rst_n_used",    32'(n_used),    0);
      @(negedge clk);
      rst_n = 1'b1;

      // Alternating stream, threshold one half
      sbQ.push_back('{"alt", 9'd128, 1'b1, ET, ET ? 9'd7 : 9'd8});
      startStream(4'd3, 9'd128);
      applyStimulus(8, 256'b01010101, 1'b0, acc);
      checkOutput(1'b0, acc);

      // All zeros against a high threshold
      sbQ.push_back('{"zeros", 9'd0, 1'b0, ET, ET ? 9'd2 : 9'd4});
      startStream(4'd2, 9'd192);
      applyStimulus(4, 256'd0, 1'b0, acc);
      checkOutput(1'b0, acc);

      // Zero threshold with gapped valid, then a stalled consumer
      sbQ.push_back('{"gaps", ET ? 9'd32 : 9'd128, 1'b1, ET, ET ? 9'd1 : 9'd8});
      startStream(4'd3, 9'd0);
      applyStimulus(8, 256'b01001101, 1'b1, acc);
      checkOutput(1'b1, acc);

      // Reset in the middle of a stream
      startStream(4'd8, 9'd200);
      applyStimulus(3, '1, 1'b0, acc);
      check("mid_accepted", 32'(acc), 3);
      rst_n = 1'b0;
      #1;
      check("mid_rst_in_ready",  32'(in_ready),  0);
      check("mid_rst_out_valid", 32'(out_valid), 0);
      check("mid_rst_value",     32'(value),     0);
      check("mid_rst_decision",  32'(decision),  0);
      check("mid_rst_early",     32'(early),     0);
      check("mid_rst_n_used",    32'(n_used),    0);
      @(negedge clk);
      rst_n = 1'b1;
      sbQ.push_back('{"restart", 9'd256, 1'b1, 1'b0, 9'd2});
      startStream(4'd1, 9'd256);
      applyStimulus(2, 256'b11, 1'b0, acc);
      checkOutput(1'b0, acc);

      // Oversized length clamps to the full 256-bit stream
      sbQ.push_back('{"clamp", 9'd256, 1'b1, 1'b0, 9'd256});
      startStream(4'd12, 9'd256);
      applyStimulus(256, '1, 1'b0, acc);
      checkOutput(1'b0, acc);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
